multicycle_controller: RTL and testbench

Control unit for the multi-cycle RV32I core. It sequences the shared datapath through one FSM: a single memory port for fetch and data, one ALU, a PC register, an instruction register (IR), an ALUOut register and the immediate extender. Each cycle it drives the datapath's select and write-enable lines from the current state and the IR fields. It sits between the IR and the datapath and is the only source of `immediate_source` for the extender.

---
 rtl/riscv_pkg.sv | 88 ++++++++
 rtl/multicycle_controller_if.sv | 37 +++
 rtl/alu_decoder.sv | 54 +++++
 rtl/multicycle_controller.sv | 210 +++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the multi-cycle RV32I control unit:
// FSM state encoding, opcodes, immediate/ALU encodings and datapath mux selects.
package riscv_pkg;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWrite = 4'd4,
        StMemWb    = 4'd5,
        StExecR    = 4'd6,
        StExecI    = 4'd7,
        StLui      = 4'd8,
        StJalrAdr  = 4'd9,
        StJal      = 4'd10,
        StAluWb    = 4'd11,
        StBranch   = 4'd12,
        StIllegal  = 4'd13
    } ctrl_state_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;

    typedef enum logic [2:0] {
        ImmI = 3'b000,
        ImmS = 3'b001,
        ImmB = 3'b010,
        ImmU = 3'b011,
        ImmJ = 3'b100
    } imm_src_e;

    typedef enum logic [2:0] {
        AluAdd = 3'b000,
        AluSub = 3'b001,
        AluAnd = 3'b010,
        AluOr  = 3'b011,
        AluXor = 3'b100,
        AluSlt = 3'b101,
        AluSll = 3'b110,
        AluSrl = 3'b111
    } alu_ctrl_e;

    // What the FSM asks of the ALU decoder in a given state.
    typedef enum logic [1:0] {
        AluOpAdd    = 2'b00,
        AluOpSub    = 2'b01,
        AluOpFunctR = 2'b10,
        AluOpFunctI = 2'b11
    } alu_op_e;

    localparam logic       AdrSrcPc     = 1'b0;
    localparam logic       AdrSrcAluOut = 1'b1;

    localparam logic [1:0] ResAluOut    = 2'b00;
    localparam logic [1:0] ResReadData  = 2'b01;
    localparam logic [1:0] ResAluResult = 2'b10;

    localparam logic [1:0] SrcAPc       = 2'b00;
    localparam logic [1:0] SrcAOldPc    = 2'b01;
    localparam logic [1:0] SrcARs1      = 2'b10;
    localparam logic [1:0] SrcAZero     = 2'b11;

    localparam logic [1:0] SrcBRs2      = 2'b00;
    localparam logic [1:0] SrcBImm      = 2'b01;
    localparam logic [1:0] SrcBFour     = 2'b10;

    // Immediate format selected purely by opcode; unknown opcodes fall back to I.
    function automatic imm_src_e imm_src_decode(input logic [6:0] opcode);
        imm_src_e imm;
        case (opcode)
            OpLoad, OpJalr, OpI: imm = ImmI;
            OpStore:             imm = ImmS;
            OpBranch:            imm = ImmB;
            OpLui:               imm = ImmU;
            OpJal:               imm = ImmJ;
            default:             imm = ImmI;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multi-cycle controller and the shared datapath.
// The controller side (master) consumes IR fields and status, and drives selects/enables.
interface multicycle_controller_if;

    logic [6:0] opcode_i;
    logic [2:0] funct3_i;
    logic       funct7b5_i;
    logic       zero_i;
    logic       mem_ready_i;

    logic       pc_write_o;
    logic       adr_src_o;
    logic       mem_write_o;
    logic       ir_write_o;
    logic       reg_write_o;
    logic [1:0] result_src_o;
    logic [1:0] alu_src_a_o;
    logic [1:0] alu_src_b_o;
    logic [2:0] alu_control_o;
    logic [2:0] immediate_source_o;
    logic       illegal_instr_o;

    modport master (
        input  opcode_i, funct3_i, funct7b5_i, zero_i, mem_ready_i,
        output pc_write_o, adr_src_o, mem_write_o, ir_write_o, reg_write_o,
               result_src_o, alu_src_a_o, alu_src_b_o, alu_control_o,
               immediate_source_o, illegal_instr_o
    );

    modport slave (
        output opcode_i, funct3_i, funct7b5_i, zero_i, mem_ready_i,
        input  pc_write_o, adr_src_o, mem_write_o, ir_write_o, reg_write_o,
               result_src_o, alu_src_a_o, alu_src_b_o, alu_control_o,
               immediate_source_o, illegal_instr_o
    );

endinterface

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: turns the FSM's request plus funct fields into an
// ALU operation, flagging funct3 encodings this core does not implement.
module alu_decoder
    import riscv_pkg::*;
#(
    parameter int unsigned RegBits = 32
) (
    input  alu_op_e    alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    output alu_ctrl_e  alu_control_o,
    output logic       unsupported_o
);

    // The funct table below is the RV32 one; any other width cannot run funct ops.
    localparam logic WidthSupported = (RegBits == 32'd32);

    // Map request and funct fields to an ALU operation.
    always_comb begin
        alu_control_o = AluAdd;
        unsupported_o = 1'b0;
        case (alu_op_i)
            AluOpAdd: alu_control_o = AluAdd;
            AluOpSub: alu_control_o = AluSub;
            AluOpFunctR, AluOpFunctI: begin
                unsupported_o = ~WidthSupported;
                case (funct3_i)
                    3'b000: begin
                        // Only register-register ops use funct7[5] to pick sub.
                        if ((alu_op_i == AluOpFunctR) && funct7b5_i) begin
                            alu_control_o = AluSub;
                        end else begin
                            alu_control_o = AluAdd;
                        end
                    end
                    3'b111:  alu_control_o = AluAnd;
                    3'b110:  alu_control_o = AluOr;
                    3'b100:  alu_control_o = AluXor;
                    3'b010:  alu_control_o = AluSlt;
                    3'b001:  alu_control_o = AluSll;
                    // sra shares this encoding and is executed as srl.
                    3'b101:  alu_control_o = AluSrl;
                    default: begin
                        // sltu: no unsigned compare in this ALU.
                        alu_control_o = AluAdd;
                        unsupported_o = 1'b1;
                    end
                endcase
            end
            default: alu_control_o = AluAdd;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore-style control FSM for the multi-cycle RV32I core. Drives the shared
// datapath's selects and enables from the state register, with memory-ready,
// branch-zero and funct3 qualifying a few outputs.
module multicycle_controller
    import riscv_pkg::*;
#(
    parameter int unsigned RegBits = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    multicycle_controller_if.master ctrl
);

    ctrl_state_e r_state;
    ctrl_state_e w_next_state;

    alu_op_e     w_alu_op;
    alu_ctrl_e   w_alu_control;
    logic        w_alu_unsupported;

    logic        w_pc_write;
    logic        w_adr_src;
    logic        w_mem_write;
    logic        w_ir_write;
    logic        w_reg_write;
    logic [1:0]  w_result_src;
    logic [1:0]  w_alu_src_a;
    logic [1:0]  w_alu_src_b;
    imm_src_e    w_imm_src;
    logic        w_illegal;

    alu_decoder #(
        .RegBits (RegBits)
    ) u_alu_decoder (
        .alu_op_i      (w_alu_op),
        .funct3_i      (ctrl.funct3_i),
        .funct7b5_i    (ctrl.funct7b5_i),
        .alu_control_o (w_alu_control),
        .unsupported_o (w_alu_unsupported)
    );

    // State register; reset returns to FETCH without waiting for a clock.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= StFetch;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state selection from current state, IR fields and memory/ALU status.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            StFetch: begin
                if (ctrl.mem_ready_i) begin
                    w_next_state = StDecode;
                end else begin
                    w_next_state = StFetch;
                end
            end
            StDecode: begin
                case (ctrl.opcode_i)
                    OpLoad, OpStore: w_next_state = StMemAdr;
                    OpR:             w_next_state = StExecR;
                    OpI:             w_next_state = StExecI;
                    OpBranch:        w_next_state = StBranch;
                    OpJal:           w_next_state = StJal;
                    OpJalr:          w_next_state = StJalrAdr;
                    OpLui:           w_next_state = StLui;
                    default:         w_next_state = StIllegal;
                endcase
            end
            StMemAdr: begin
                if (ctrl.opcode_i == OpStore) begin
                    w_next_state = StMemWrite;
                end else begin
                    w_next_state = StMemRead;
                end
            end
            StMemRead: begin
                if (ctrl.mem_ready_i) begin
                    w_next_state = StMemWb;
                end else begin
                    w_next_state = StMemRead;
                end
            end
            StMemWrite: begin
                if (ctrl.mem_ready_i) begin
                    w_next_state = StFetch;
                end else begin
                    w_next_state = StMemWrite;
                end
            end
            StMemWb: w_next_state = StFetch;
            StExecR, StExecI: begin
                // An unimplemented funct aborts before any register write.
                if (w_alu_unsupported) begin
                    w_next_state = StIllegal;
                end else begin
                    w_next_state = StAluWb;
                end
            end
            StLui:     w_next_state = StAluWb;
            StJalrAdr: w_next_state = StJal;
            StJal:     w_next_state = StAluWb;
            StAluWb:   w_next_state = StFetch;
            StBranch:  w_next_state = StFetch;
            StIllegal: w_next_state = StIllegal;
            default:   w_next_state = StIllegal;
        endcase
    end

    // Datapath control decoded from the state; held at the idle vector during reset.
    always_comb begin
        w_pc_write   = 1'b0;
        w_adr_src    = AdrSrcPc;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_result_src = ResAluOut;
        w_alu_src_a  = SrcAPc;
        w_alu_src_b  = SrcBRs2;
        w_alu_op     = AluOpAdd;
        w_imm_src    = ImmI;
        w_illegal    = 1'b0;
        if (!rst_ni) begin
            // Reset wins asynchronously so no write strobe survives it.
            w_alu_src_b = SrcBFour;
        end else begin
            w_imm_src = imm_src_decode(ctrl.opcode_i);
            case (r_state)
                StFetch: begin
                    w_adr_src    = AdrSrcPc;
                    w_alu_src_a  = SrcAPc;
                    w_alu_src_b  = SrcBFour;
                    w_result_src = ResAluResult;
                    w_ir_write   = ctrl.mem_ready_i;
                    w_pc_write   = ctrl.mem_ready_i;
                end
                StDecode: begin
                    // Branch/jal target OldPC + imm lands in ALUOut here.
                    w_alu_src_a = SrcAOldPc;
                    w_alu_src_b = SrcBImm;
                end
                StMemAdr, StJalrAdr: begin
                    w_alu_src_a = SrcARs1;
                    w_alu_src_b = SrcBImm;
                end
                StMemRead: w_adr_src = AdrSrcAluOut;
                StMemWrite: begin
                    w_adr_src   = AdrSrcAluOut;
                    w_mem_write = 1'b1;
                end
                StMemWb: begin
                    w_result_src = ResReadData;
                    w_reg_write  = 1'b1;
                end
                StExecR: begin
                    w_alu_src_a = SrcARs1;
                    w_alu_src_b = SrcBRs2;
                    w_alu_op    = AluOpFunctR;
                end
                StExecI: begin
                    w_alu_src_a = SrcARs1;
                    w_alu_src_b = SrcBImm;
                    w_alu_op    = AluOpFunctI;
                end
                StLui: begin
                    w_alu_src_a = SrcAZero;
                    w_alu_src_b = SrcBImm;
                end
                StJal: begin
                    // PC takes the target from ALUOut while ALU forms the link OldPC + 4.
                    w_alu_src_a  = SrcAOldPc;
                    w_alu_src_b  = SrcBFour;
                    w_result_src = ResAluOut;
                    w_pc_write   = 1'b1;
                end
                StAluWb: begin
                    w_result_src = ResAluOut;
                    w_reg_write  = 1'b1;
                end
                StBranch: begin
                    w_alu_src_a  = SrcARs1;
                    w_alu_src_b  = SrcBRs2;
                    w_alu_op     = AluOpSub;
                    w_result_src = ResAluOut;
                    w_pc_write   = ((ctrl.funct3_i == 3'b000) &  ctrl.zero_i) |
                                   ((ctrl.funct3_i == 3'b001) & ~ctrl.zero_i);
                end
                StIllegal: w_illegal = 1'b1;
                default:   w_illegal = 1'b1;
            endcase
        end
    end

    assign ctrl.pc_write_o         = w_pc_write;
    assign ctrl.adr_src_o          = w_adr_src;
    assign ctrl.mem_write_o        = w_mem_write;
    assign ctrl.ir_write_o         = w_ir_write;
    assign ctrl.reg_write_o        = w_reg_write;
    assign ctrl.result_src_o       = w_result_src;
    assign ctrl.alu_src_a_o        = w_alu_src_a;
    assign ctrl.alu_src_b_o        = w_alu_src_b;
    assign ctrl.alu_control_o      = w_alu_control;
    assign ctrl.immediate_source_o = w_imm_src;
    assign ctrl.illegal_instr_o    = w_illegal;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class cycle by
// cycle and compares the full control vector against hand-written expectations.
module tb_multicycle_controller;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_BAD  = 7'h7F;

    logic clk_i = 1'b0;
    logic rst_ni;

    multicycle_controller_if dut_if ();

    multicycle_controller #(
        .RegBits (32)
    ) u_dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .ctrl   (dut_if)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    logic [17:0] obs_vec;
    assign obs_vec = {dut_if.pc_write_o, dut_if.adr_src_o, dut_if.mem_write_o,
                      dut_if.ir_write_o, dut_if.reg_write_o, dut_if.result_src_o,
                      dut_if.alu_src_a_o, dut_if.alu_src_b_o, dut_if.alu_control_o,
                      dut_if.immediate_source_o, dut_if.illegal_instr_o};

    // Field order: pc_write adr_src mem_write ir_write reg_write result_src A B alu imm illegal
    function automatic logic [17:0] ctl(input logic pcw, input logic adr, input logic mw,
                                        input logic irw, input logic rw, input logic [1:0] rs,
                                        input logic [1:0] a, input logic [1:0] b,
                                        input logic [2:0] alu, input logic [2:0] imm,
                                        input logic ill);
        return {pcw, adr, mw, irw, rw, rs, a, b, alu, imm, ill};
    endfunction

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Sample one cycle's outputs mid-cycle, then advance past the next rising edge.
    task automatic expect_cycle(input string tag, input logic [17:0] exp);
        #1;
        check_value(tag, {14'd0, obs_vec}, {14'd0, exp});
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7b5);
        dut_if.opcode_i   = op;
        dut_if.funct3_i   = f3;
        dut_if.funct7b5_i = f7b5;
    endtask

    task automatic apply_reset();
        rst_ni = 1'b0;
        dut_if.mem_ready_i = 1'b0;
        #1;
        check_value("reset_vec", {14'd0, obs_vec},
                    {14'd0, ctl(0,0,0,0,0,2'b00,2'b00,2'b10,3'b000,3'b000,0)});
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic do_branch(input string tag, input logic [2:0] f3, input logic zero,
                             input logic exp_pcw);
        set_instr(OP_BR, f3, 1'b0);
        dut_if.zero_i = zero;
        dut_if.mem_ready_i = 1'b1;
        expect_cycle({tag, "_fetch"},  ctl(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,3'b010,0));
        expect_cycle({tag, "_decode"}, ctl(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,3'b010,0));
        expect_cycle({tag, "_branch"}, ctl(exp_pcw,0,0,0,0,2'b00,2'b10,2'b00,3'b001,3'b010,0));
        dut_if.zero_i = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0;
        dut_if.opcode_i    = 7'd0;
        dut_if.funct3_i    = 3'd0;
        dut_if.funct7b5_i  = 1'b0;
        dut_if.zero_i      = 1'b0;
        dut_if.mem_ready_i = 1'b0;

        // Reset and idle FETCH waiting on memory.
        apply_reset();
        expect_cycle("fetch_wait0", ctl(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,3'b000,0));
        expect_cycle("fetch_wait1", ctl(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,3'b000,0));

        // lw 0x00402083 with zero wait states: 5 cycles.
        set_instr(OP_LW, 3'b010, 1'b0);
        dut_if.mem_ready_i = 1'b1;
        expect_cycle("lw_fetch",   ctl(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,3'b000,0));
        expect_cycle("lw_decode",  ctl(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,3'b000,0));
        expect_cycle("lw_memadr",  ctl(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,3'b000,0));
        expect_cycle("lw_memread", ctl(0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,3'b000,0));
        expect_cycle("lw_memwb",   ctl(0,0,0,0,1,2'b01,2'b00,2'b00,3'b000,3'b000,0));

        // sw with three wait states in MEMWRITE.
        set_instr(OP_SW, 3'b010, 1'b0);
        expect_cycle("sw_fetch",  ctl(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,3'b001,0));
        expect_cycle("sw_decode", ctl(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,3'b001,0));
        expect_cycle("sw_memadr", ctl(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,3'b001,0));
        dut_if.mem_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_cycle("sw_memwrite_wait", ctl(0,1,1,0,0,2'b00,2'b00,2'b00,3'b000,3'b001,0));
        end
        dut_if.mem_ready_i = 1'b1;
        expect_cycle("sw_memwrite_done", ctl(0,1,1,0,0,2'b00,2'b00,2'b00,3'b000,3'b001,0));

        // Branches: beq/bne taken and not taken.
        do_branch("beq_z1", 3'b000, 1'b1, 1'b1);
        do_branch("beq_z0", 3'b000, 1'b0, 1'b0);
        do_branch("bne_z0", 3'b001, 1'b0, 1'b1);
        do_branch("bne_z1", 3'b001, 1'b1, 1'b0);

        // jal: 4 cycles.
        set_instr(OP_JAL, 3'b000, 1'b0);
        expect_cycle("jal_fetch",  ctl(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,3'b100,0));
        expect_cycle("jal_decode", ctl(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,3'b100,0));
        expect_cycle("jal_jal",    ctl(1,0,0,0,0,2'b00,2'b01,2'b10,3'b000,3'b100,0));
        expect_cycle("jal_aluwb",  ctl(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,3'b100,0));

        // jalr: 5 cycles through JALRADR.
        set_instr(OP_JALR, 3'b000, 1'b0);
        expect_cycle("jalr_fetch",   ctl(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,3'b000,0));
        expect_cycle("jalr_decode",  ctl(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,3'b000,0));
        expect_cycle("jalr_adr",     ctl(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,3'b000,0));
        expect_cycle("jalr_jal",     ctl(1,0,0,0,0,2'b00,2'b01,2'b10,3'b000,3'b000,0));
        expect_cycle("jalr_aluwb",   ctl(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,3'b000,0));

        // R-type sub.
        set_instr(OP_R, 3'b000, 1'b1);
        expect_cycle("sub_fetch",  ctl(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,3'b000,0));
        expect_cycle("sub_decode", ctl(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,3'b000,0));
        expect_cycle("sub_execr",  ctl(0,0,0,0,0,2'b00,2'b10,2'b00,3'b001,3'b000,0));
        expect_cycle("sub_aluwb",  ctl(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,3'b000,0));

        // R-type xor: only the EXECR op differs.
        set_instr(OP_R, 3'b100, 1'b0);
        expect_cycle("xor_fetch",  ctl(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,3'b000,0));
        expect_cycle("xor_decode", ctl(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,3'b000,0));
        expect_cycle("xor_execr",  ctl(0,0,0,0,0,2'b00,2'b10,2'b00,3'b100,3'b000,0));
        expect_cycle("xor_aluwb",  ctl(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,3'b000,0));

        // addi with funct7b5 set must still add.
        set_instr(OP_I, 3'b000, 1'b1);
        expect_cycle("addi_fetch",  ctl(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,3'b000,0));
        expect_cycle("addi_decode", ctl(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,3'b000,0));
        expect_cycle("addi_execi",  ctl(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,3'b000,0));
        expect_cycle("addi_aluwb",  ctl(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,3'b000,0));

        // srai executes as srl; slli as sll.
        set_instr(OP_I, 3'b101, 1'b1);
        expect_cycle("srai_fetch",  ctl(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,3'b000,0));
        expect_cycle("srai_decode", ctl(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,3'b000,0));
        expect_cycle("srai_execi",  ctl(0,0,0,0,0,2'b00,2'b10,2'b01,3'b111,3'b000,0));
        expect_cycle("srai_aluwb",  ctl(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,3'b000,0));
        set_instr(OP_I, 3'b001, 1'b0);
        expect_cycle("slli_fetch",  ctl(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,3'b000,0));
        expect_cycle("slli_decode", ctl(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,3'b000,0));
        expect_cycle("slli_execi",  ctl(0,0,0,0,0,2'b00,2'b10,2'b01,3'b110,3'b000,0));
        expect_cycle("slli_aluwb",  ctl(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,3'b000,0));

        // lui: zero + immediate.
        set_instr(OP_LUI, 3'b000, 1'b0);
        expect_cycle("lui_fetch",  ctl(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,3'b011,0));
        expect_cycle("lui_decode", ctl(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,3'b011,0));
        expect_cycle("lui_lui",    ctl(0,0,0,0,0,2'b00,2'b11,2'b01,3'b000,3'b011,0));
        expect_cycle("lui_aluwb",  ctl(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,3'b011,0));

        // sltu is unsupported: EXECR then ILLEGAL with no writes.
        set_instr(OP_R, 3'b011, 1'b0);
        expect_cycle("sltu_fetch",   ctl(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,3'b000,0));
        expect_cycle("sltu_decode",  ctl(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,3'b000,0));
        expect_cycle("sltu_execr",   ctl(0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,3'b000,0));
        expect_cycle("sltu_illegal", ctl(0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,3'b000,1));

        // Reset during a held MEMWRITE drops the strobe at once.
        apply_reset();
        set_instr(OP_SW, 3'b010, 1'b0);
        dut_if.mem_ready_i = 1'b1;
        expect_cycle("swr_fetch",  ctl(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,3'b001,0));
        expect_cycle("swr_decode", ctl(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,3'b001,0));
        expect_cycle("swr_memadr", ctl(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,3'b001,0));
        dut_if.mem_ready_i = 1'b0;
        expect_cycle("swr_memwrite0", ctl(0,1,1,0,0,2'b00,2'b00,2'b00,3'b000,3'b001,0));
        expect_cycle("swr_memwrite1", ctl(0,1,1,0,0,2'b00,2'b00,2'b00,3'b000,3'b001,0));
        apply_reset();
        expect_cycle("swr_refetch_wait", ctl(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,3'b001,0));

        // Illegal opcode 0x7F: sticky flag for 10 cycles, no enables even with ready high.
        set_instr(OP_BAD, 3'b000, 1'b0);
        dut_if.mem_ready_i = 1'b1;
        expect_cycle("bad_fetch",  ctl(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,3'b000,0));
        expect_cycle("bad_decode", ctl(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,3'b000,0));
        for (int i = 0; i < 10; i++) begin
            expect_cycle("bad_illegal_hold", ctl(0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,3'b000,1));
        end
        rst_ni = 1'b0;
        #1;
        check_value("illegal_async_clear", {31'd0, dut_if.illegal_instr_o}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
